// File: rtl/instr_mem_arbiter_pkg.sv
// instr_mem_arbiter_pkg: shared widths, port ids and arbitration modes for the instruction memory arbiter
package instr_mem_arbiter_pkg;
  localparam int INSTR_ADDR_WIDTH = 32;
  localparam int INSTR_WORD_WIDTH = 32;
  localparam int PRIO_RR = 0;
  localparam int PRIO_FIXED = 1;
  typedef enum logic {PORT_F, PORT_D} port_id_e;
endpackage

// File: rtl/instr_arb_sel.sv
// instr_arb_sel: combinational winner selection between fetch and debug requests
module instr_arb_sel
  import instr_mem_arbiter_pkg::*;
#(
  parameter int PRIO_MODE = PRIO_RR
) (
  input  logic     i_f_req,
  input  logic     i_d_req,
  input  port_id_e i_last,
  input  logic     i_wait_exp,
  output logic     o_f_gnt,
  output logic     o_d_gnt
);
  logic w_d_wins;
  always_comb begin
    w_d_wins = (PRIO_MODE == PRIO_FIXED) ? i_wait_exp : (i_last == PORT_F);
    o_f_gnt = i_f_req & ~(i_d_req & w_d_wins);
    o_d_gnt = i_d_req & ~o_f_gnt;
  end
endmodule

// File: rtl/instr_mem_arbiter.sv
// instr_mem_arbiter: shares a 1-cycle-latency instruction memory read port between fetch (F) and debug (D)
module instr_mem_arbiter
  import instr_mem_arbiter_pkg::*;
#(
  parameter int PRIO_MODE = 0,
  parameter int MAX_WAIT  = 8
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        f_req_i,
  input  logic [INSTR_ADDR_WIDTH-1:0] f_addr_i,
  input  logic                        f_kill_i,
  output logic                        f_gnt_o,
  output logic                        f_rvalid_o,
  output logic [INSTR_WORD_WIDTH-1:0] f_rdata_o,
  output logic                        f_err_o,
  input  logic                        d_req_i,
  input  logic [INSTR_ADDR_WIDTH-1:0] d_addr_i,
  output logic                        d_gnt_o,
  output logic                        d_rvalid_o,
  output logic [INSTR_WORD_WIDTH-1:0] d_rdata_o,
  output logic                        d_err_o,
  output logic                        mem_en_o,
  output logic [INSTR_ADDR_WIDTH-1:0] mem_addr_o,
  input  logic [INSTR_WORD_WIDTH-1:0] mem_rdata_i
);
  logic                        w_f_req, w_d_req, w_f_gnt, w_d_gnt, w_gnt, w_mis, w_f_rsp, w_d_rsp;
  logic [INSTR_ADDR_WIDTH-1:0] w_addr;
  port_id_e                    r_last, r_owner;
  logic                        r_valid, r_err;
  logic [7:0]                  r_wait;
  assign w_f_req = f_req_i & ~f_kill_i & ~rst_i;
  assign w_d_req = d_req_i & ~rst_i;
  instr_arb_sel #(.PRIO_MODE(PRIO_MODE)) u_sel (
    .i_f_req   (w_f_req),
    .i_d_req   (w_d_req),
    .i_last    (r_last),
    .i_wait_exp(r_wait == 8'(MAX_WAIT)),
    .o_f_gnt   (w_f_gnt),
    .o_d_gnt   (w_d_gnt)
  );
  always_comb begin
    w_gnt = w_f_gnt | w_d_gnt;
    w_addr = w_f_gnt ? f_addr_i : w_d_gnt ? d_addr_i : '0;
    w_mis = w_addr[1:0] != 2'b00;
  end
  assign f_gnt_o = w_f_gnt;
  assign d_gnt_o = w_d_gnt;
  assign mem_en_o = w_gnt & ~w_mis;
  assign mem_addr_o = w_addr;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_last  <= PORT_D;
      r_owner <= PORT_F;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_wait  <= '0;
    end else begin
      r_last  <= w_gnt ? (w_f_gnt ? PORT_F : PORT_D) : r_last;
      r_owner <= w_d_gnt ? PORT_D : PORT_F;
      r_valid <= w_gnt;
      r_err   <= w_mis;
      r_wait  <= (~d_req_i | w_d_gnt) ? '0 : (r_wait == 8'(MAX_WAIT)) ? r_wait : r_wait + 8'd1;
    end
  end
  // read data comes straight from the memory; only owner/valid/err are held
  assign w_f_rsp = ~rst_i & r_valid & (r_owner == PORT_F) & ~f_kill_i;
  assign w_d_rsp = ~rst_i & r_valid & (r_owner == PORT_D);
  assign f_rvalid_o = w_f_rsp;
  assign f_err_o = w_f_rsp & r_err;
  assign f_rdata_o = (w_f_rsp & ~r_err) ? mem_rdata_i : '0;
  assign d_rvalid_o = w_d_rsp;
  assign d_err_o = w_d_rsp & r_err;
  assign d_rdata_o = (w_d_rsp & ~r_err) ? mem_rdata_i : '0;
endmodule

// File: tb/tb_instr_mem_arbiter.sv
// tb_instr_mem_arbiter: round-robin and fixed-priority arbiters driven in parallel against a queue-based model
module tb_instr_mem_arbiter;
  typedef struct {
    int          cyc;
    logic        err;
    logic [31:0] data;
  } resp_t;
  logic        clk = 1'b0;
  logic        rst = 1'b1, f_req = 1'b0, f_kill = 1'b0, d_req = 1'b0;
  logic [31:0] f_addr = '0, d_addr = '0;
  logic [1:0]  f_gnt, f_rvalid, f_err, d_gnt, d_rvalid, d_err, mem_en;
  logic [31:0] f_rdata [2];
  logic [31:0] d_rdata [2];
  logic [31:0] mem_addr [2];
  logic [31:0] mem_rdata [2];
  logic [1:0]  exp_fg = '0, exp_dg = '0, exp_en = '0;
  logic [31:0] exp_addr [2];
  resp_t       q [4][$];
  int          last_d [2];
  int          waited [2];
  int          cyc = 0, checks = 0, passed = 0;
  localparam int FP_WAIT = 3;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  instr_mem_arbiter #(.PRIO_MODE(0), .MAX_WAIT(8)) dut_rr (
    .clk_i(clk), .rst_i(rst),
    .f_req_i(f_req), .f_addr_i(f_addr), .f_kill_i(f_kill),
    .f_gnt_o(f_gnt[0]), .f_rvalid_o(f_rvalid[0]), .f_rdata_o(f_rdata[0]), .f_err_o(f_err[0]),
    .d_req_i(d_req), .d_addr_i(d_addr),
    .d_gnt_o(d_gnt[0]), .d_rvalid_o(d_rvalid[0]), .d_rdata_o(d_rdata[0]), .d_err_o(d_err[0]),
    .mem_en_o(mem_en[0]), .mem_addr_o(mem_addr[0]), .mem_rdata_i(mem_rdata[0])
  );
  instr_mem_arbiter #(.PRIO_MODE(1), .MAX_WAIT(FP_WAIT)) dut_fp (
    .clk_i(clk), .rst_i(rst),
    .f_req_i(f_req), .f_addr_i(f_addr), .f_kill_i(f_kill),
    .f_gnt_o(f_gnt[1]), .f_rvalid_o(f_rvalid[1]), .f_rdata_o(f_rdata[1]), .f_err_o(f_err[1]),
    .d_req_i(d_req), .d_addr_i(d_addr),
    .d_gnt_o(d_gnt[1]), .d_rvalid_o(d_rvalid[1]), .d_rdata_o(d_rdata[1]), .d_err_o(d_err[1]),
    .mem_en_o(mem_en[1]), .mem_addr_o(mem_addr[1]), .mem_rdata_i(mem_rdata[1])
  );
  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a == 32'h40) ? 32'h0000_0013 : {a[15:0] ^ 16'hA5A5, a[15:0]};
  endfunction
  // memory returns garbage when not enabled so a missing rdata mask shows up
  always @(posedge clk)
    for (int k = 0; k < 2; k++) mem_rdata[k] <= mem_en[k] ? mem_fn(mem_addr[k]) : 32'hBAD0_BAD0;
  task automatic chk(input string n, input int k, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got === want) passed++;
    else $display("FAIL %s dut%0d cyc %0d got %h want %h", n, k, cyc, got, want);
  endtask
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      chk("grant", k, {29'd0, f_gnt[k], d_gnt[k], mem_en[k], mem_addr[k]},
          {29'd0, exp_fg[k], exp_dg[k], exp_en[k], exp_addr[k]});
      for (int p = 0; p < 2; p++) begin
        logic [63:0] want, got;
        resp_t e;
        want = '0;
        if (q[k*2+p].size() > 0 && q[k*2+p][0].cyc == cyc) begin
          e = q[k*2+p].pop_front();
          want = {30'd0, 1'b1, e.err, e.data};
        end
        got = p == 0 ? {30'd0, f_rvalid[k], f_err[k], f_rdata[k]} : {30'd0, d_rvalid[k], d_err[k], d_rdata[k]};
        chk(p == 0 ? "f_rsp" : "d_rsp", k, got, want);
      end
    end
  end
  task automatic model();
    for (int k = 0; k < 2; k++) begin
      logic ef, gf, gd, dwin;
      logic [31:0] a;
      if (rst) begin
        exp_fg[k] = 0; exp_dg[k] = 0; exp_en[k] = 0; exp_addr[k] = '0;
        last_d[k] = 1; waited[k] = 0;
        q[k*2].delete(); q[k*2+1].delete();
        continue;
      end
      if (f_kill && q[k*2].size() > 0 && q[k*2][$].cyc == cyc) void'(q[k*2].pop_back());
      ef = f_req && !f_kill;
      dwin = (k == 0) ? (last_d[k] == 0) : (waited[k] >= FP_WAIT);
      gf = ef && !(d_req && dwin);
      gd = d_req && !gf;
      a = gf ? f_addr : gd ? d_addr : 32'd0;
      exp_fg[k] = gf; exp_dg[k] = gd; exp_addr[k] = a;
      exp_en[k] = (gf || gd) && a % 4 == 0;
      if (gf || gd) begin
        last_d[k] = gd ? 1 : 0;
        q[k*2 + (gd ? 1 : 0)].push_back('{cyc + 1, a % 4 != 0, a % 4 != 0 ? 32'd0 : mem_fn(a)});
      end
      waited[k] = (d_req && !gd) ? (waited[k] < FP_WAIT ? waited[k] + 1 : FP_WAIT) : 0;
    end
  endtask
  task automatic step(input logic r, input logic fr, input logic [31:0] fa, input logic fk,
                      input logic dr, input logic [31:0] da);
    @(posedge clk);
    #1;
    rst = r; f_req = fr; f_addr = fa; f_kill = fk; d_req = dr; d_addr = da;
    model();
  endtask
  function automatic logic [31:0] rnd_addr();
    logic [31:0] a;
    a = $urandom & 32'h3FC;
    if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(1, 3));
    return a;
  endfunction
  initial begin
    int left;
    exp_addr[0] = '0; exp_addr[1] = '0;
    step(1, 1, 32'h40, 0, 1, 32'h100);
    step(1, 1, 32'h40, 0, 1, 32'h100);
    step(0, 1, 32'h40, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    repeat (4) step(0, 1, 32'h0, 0, 1, 32'h100);
    step(0, 0, 0, 0, 0, 0);
    repeat (6) step(0, 1, 32'h0, 0, 1, 32'h100);
    step(0, 0, 0, 0, 1, 32'h102);
    step(0, 0, 0, 0, 0, 0);
    step(0, 1, 32'h80, 0, 0, 0);
    step(0, 1, 32'h80, 1, 1, 32'h200);
    step(0, 0, 0, 0, 0, 0);
    step(0, 1, 32'h44, 0, 0, 0);
    step(1, 1, 32'h44, 0, 0, 0);
    step(0, 1, 32'h48, 0, 1, 32'h104);
    step(0, 0, 0, 0, 0, 0);
    repeat (2000)
      step($urandom_range(0, 63) == 0, $urandom_range(0, 2) != 0, rnd_addr(),
           $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1, rnd_addr());
    repeat (3) step(0, 0, 0, 0, 0, 0);
    @(posedge clk);
    left = 0;
    for (int i = 0; i < 4; i++) left += q[i].size();
    chk("drained", 0, 64'(left), 64'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/instr_mem_arbiter.md
Name: instr_mem_arbiter

Overview:
- Shares the single-read-port, byte-addressed instruction memory (1-cycle read latency, word-aligned access) between two requesters: the CPU fetch stage (port F) and the bench/debug read port (port D).
- Uses per-port req/gnt/rvalid handshakes.
- Steers the registered read data back to the owner of the access.
- Flags misaligned accesses.
- Supports squashing of in-flight fetch responses on redirect.

Parameters:
PRIO_MODE, 0, 0 = round-robin between F and D; 1 = fixed priority to F with D starvation guard
MAX_WAIT, 8, cycles D may be refused in PRIO_MODE=1 before D is forced to win; range 1..255

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, synchronous, active-high
f_req_i  in  1  fetch request; held with f_addr_i stable until f_gnt_o
f_addr_i  in  INSTR_ADDR_WIDTH  fetch byte address
f_kill_i  in  1  fetch redirect: masks f_req_i and squashes f_rvalid_o this cycle
f_gnt_o  out  1  fetch request accepted this cycle
f_rvalid_o  out  1  fetch response valid
f_rdata_o  out  INSTR_WORD_WIDTH  fetch response data
f_err_o  out  1  fetch response is misaligned-address error
d_req_i  in  1  debug request; held with d_addr_i stable until d_gnt_o
d_addr_i  in  INSTR_ADDR_WIDTH  debug byte address
d_gnt_o  out  1  debug request accepted this cycle
d_rvalid_o  out  1  debug response valid
d_rdata_o  out  INSTR_WORD_WIDTH  debug response data
d_err_o  out  1  debug response is misaligned-address error
mem_en_o  out  1  memory read enable
mem_addr_o  out  INSTR_ADDR_WIDTH  memory byte address
mem_rdata_i  in  INSTR_WORD_WIDTH  memory read data, valid the cycle after mem_en_o

Behaviour:
- Clocking and reset: one clock clk_i; reset rst_i is synchronous and active-high.
- While rst_i is high, all outputs are 0 (gnt, rvalid, err, rdata, mem_en_o, mem_addr_o).
- Reset clears the RR pointer (points to D, so F wins the first contest), the wait counter, and the response-owner/valid registers.
- A response whose grant was in the cycle rst_i was high is never delivered.
- Grant is combinational in the request cycle N.
- At most one gnt per cycle; gnt only when the corresponding effective req is high.
- Effective F request = f_req_i & ~f_kill_i.
- mem_addr_o = granted port's address; 0 when no grant.
- mem_en_o = grant & (granted addr[1:0] == 0).
- Misaligned (addr[1:0] != 0): the grant is still issued, mem_en_o stays 0, and the response carries err=1, rdata=0.
- Response timing: exactly cycle N+1.
  - Owner's rvalid_o = 1 and rdata_o = mem_rdata_i (or 0 on error).
  - Non-owner's rvalid/rdata/err = 0.
- Registered state is owner id, valid and err; data is not re-registered, so latency from grant to rvalid is 1.
- f_kill_i high in N+1 forces f_rvalid_o = 0 and f_err_o = 0 for a pending F response (discarded, not retried). Killing does not affect D.
- Back-to-back: a new grant in N+1 is allowed alongside the N response; throughput is 1 access/cycle.
- Arbitration in PRIO_MODE=0:
  - Both requesting: grant the port not granted last.
  - Pointer updates only on a grant.
- Arbitration in PRIO_MODE=1:
  - F wins contests.
  - 8-bit wait_cnt increments each cycle d_req_i=1 and d_gnt_o=0, saturating at MAX_WAIT.
  - When wait_cnt == MAX_WAIT, D wins the contest.
  - wait_cnt clears on d_gnt_o or when d_req_i=0.
- Requests are not queued; a refused requester keeps req high. Dropping req before gnt is legal (the request is abandoned).

Decomposition:
- tb_pkg additions:
  - port_id_e enum {PORT_F, PORT_D}
  - PRIO_RR / PRIO_FIXED localparams
  - reuse INSTR_ADDR_WIDTH, INSTR_WORD_WIDTH
- One sub-module, instr_arb_sel: combinational winner selection from effective reqs, RR pointer, PRIO_MODE and the wait-expired flag.
- Top level holds the pointer, wait counter, response registers and data steering.

Test Plan:
- Only F, addr 0x40, mem returns 0x00000013 -> f_gnt_o=1, mem_en_o=1, mem_addr_o=0x40 in N; f_rvalid_o=1, f_rdata_o=0x00000013 in N+1; D outputs 0.
- PRIO_MODE=0, F and D held high 4 cycles with addrs 0x0 and 0x100 -> grants F,D,F,D; responses alternate to the correct port each following cycle.
- PRIO_MODE=1, MAX_WAIT=3, both held high -> F granted cycles 0-2, D granted cycle 3, then F resumes; wait_cnt back to 0.
- D addr 0x102 -> d_gnt_o=1, mem_en_o=0; next cycle d_rvalid_o=1, d_err_o=1, d_rdata_o=0.
- F granted addr 0x80 in N, f_kill_i=1 in N+1 with f_req_i=1 -> f_rvalid_o=0 and f_gnt_o=0 in N+1; a D request in N+1 is granted.
- rst_i asserted in the cycle after an F grant -> no f_rvalid_o ever appears; all outputs 0 during reset; F wins the first contest after release.
